// File: rtl/mem2axi4l_bridge_pkg.sv
// Shared definitions for the native-memory to AXI4-Lite bridge:
// AXI response codes and the bridge state encoding.
package mem2axi4l_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_AW_W,
    ST_WR_B,
    ST_RD_AR,
    ST_RD_R,
    ST_RESP
  } bridge_state_e;

  // EXOKAY has no meaning for a single-beat AXI4-Lite access, so only OKAY passes.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/mem2axi4l_bridge.sv
// Native valid/ready memory initiator to AXI4-Lite master, one transaction in flight.
// Optional per-phase wait timeout enabled by defining MEM2AXI4L_TIMEOUT_EN.
//
// state       | meaning
// ST_IDLE     | waiting for mem_valid_i, latches the request
// ST_WR_AW_W  | AW and W offered, each retired on its own handshake
// ST_WR_B     | waiting for the write response
// ST_RD_AR    | AR offered until arready_i
// ST_RD_R     | waiting for read data
// ST_RESP     | one-cycle mem_ready_o pulse back to the initiator
module mem2axi4l_bridge
  import mem2axi4l_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mem_valid_i,
  input  logic                    mem_instr_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] mem_wstrb_i,
  output logic [DATA_WIDTH-1:0]   mem_rdata_o,
  output logic                    mem_ready_o,
  output logic                    mem_err_o,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic [2:0]              awprot_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  output logic [ADDR_WIDTH-1:0]   araddr_o,
  output logic [2:0]              arprot_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic                    rvalid_i,
  output logic                    rready_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  bridge_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [2:0]            prot_q, prot_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d, ready_q, ready_d, err_q, err_d;

`ifdef MEM2AXI4L_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    prot_d    = prot_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ready_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid_i) begin
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          wstrb_d = mem_wstrb_i;
          prot_d  = {mem_instr_i, 2'b00};
          err_d   = 1'b0;
          if (|mem_wstrb_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_AR;
          end
        end
      end
      ST_WR_AW_W: begin
        awvalid_d = awvalid_q & ~awready_i;
        wvalid_d  = wvalid_q & ~wready_i;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_B;
        end
      end
      ST_WR_B: begin
        if (bvalid_i) begin
          bready_d = 1'b0;
          err_d    = resp_is_err(bresp_i);
          ready_d  = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RD_AR: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_R;
        end
      end
      ST_RD_R: begin
        if (rvalid_i) begin
          rdata_d  = rdata_i;
          err_d    = resp_is_err(rresp_i);
          rready_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef MEM2AXI4L_TIMEOUT_EN
    // A partial AW/W handshake does not restart the count: the limit is per state.
    tmo_d = '0;
    if ((state_q inside {ST_WR_AW_W, ST_WR_B, ST_RD_AR, ST_RD_R}) && (state_d == state_q)) begin
      if (tmo_q == TMO_LAST) begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        rdata_d   = '1;
        err_d     = 1'b1;
        ready_d   = 1'b1;
        state_d   = ST_RESP;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      prot_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ready_q   <= 1'b0;
`ifdef MEM2AXI4L_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      prot_q    <= prot_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ready_q   <= ready_d;
`ifdef MEM2AXI4L_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign awaddr_o    = addr_q;
  assign araddr_o    = addr_q;
  assign awprot_o    = prot_q;
  assign arprot_o    = prot_q;
  assign awvalid_o   = awvalid_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wstrb_q;
  assign wvalid_o    = wvalid_q;
  assign bready_o    = bready_q;
  assign arvalid_o   = arvalid_q;
  assign rready_o    = rready_q;
  assign mem_rdata_o = rdata_q;
  assign mem_ready_o = ready_q;
  assign mem_err_o   = err_q;

endmodule

// File: tb/tb_mem2axi4l_bridge.sv
// Directed bench for mem2axi4l_bridge with a small AXI4-Lite slave model.
// The timeout section is compiled only when MEM2AXI4L_TIMEOUT_EN is defined.
module tb_mem2axi4l_bridge;
  import mem2axi4l_bridge_pkg::*;

`ifdef MEM2AXI4L_TIMEOUT_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 1024;
`endif

  logic clk_i, rst_i;
  logic mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic [31:0] mem_rdata_o;
  logic mem_ready_o, mem_err_o;
  logic [31:0] awaddr_o, wdata_o, araddr_o;
  logic [2:0] awprot_o, arprot_o;
  logic [3:0] wstrb_o;
  logic awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o;
  logic awready, wready, arready, bvalid, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;

  mem2axi4l_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_valid_i(mem_valid), .mem_instr_i(mem_instr), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_wstrb_i(mem_wstrb),
    .mem_rdata_o(mem_rdata_o), .mem_ready_o(mem_ready_o), .mem_err_o(mem_err_o),
    .awaddr_o(awaddr_o), .awprot_o(awprot_o), .awvalid_o(awvalid_o), .awready_i(awready),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready),
    .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready_o),
    .araddr_o(araddr_o), .arprot_o(arprot_o), .arvalid_o(arvalid_o), .arready_i(arready),
    .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(rready_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // slave model configuration, written only by the main sequence
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  bit ar_stuck = 1'b0;
  logic [1:0] b_resp_cfg = RESP_OKAY, r_resp_cfg = RESP_OKAY;
  logic [31:0] r_data_cfg = '0;

  initial begin
    awready = 1'b0;
    forever begin
      @(negedge clk_i);
      awready = 1'b0;
      if (awvalid_o && !rst_i) begin
        for (int i = 0; i < aw_dly; i++) @(negedge clk_i);
        awready = 1'b1;
      end
    end
  end

  initial begin
    wready = 1'b0;
    forever begin
      @(negedge clk_i);
      wready = 1'b0;
      if (wvalid_o && !rst_i) begin
        for (int i = 0; i < w_dly; i++) @(negedge clk_i);
        wready = 1'b1;
      end
    end
  end

  initial begin
    arready = 1'b0;
    forever begin
      @(negedge clk_i);
      arready = 1'b0;
      if (arvalid_o && !rst_i && !ar_stuck) begin
        for (int i = 0; i < ar_dly; i++) @(negedge clk_i);
        arready = 1'b1;
      end
    end
  end

  initial begin
    bvalid = 1'b0;
    bresp  = 2'b00;
    forever begin
      @(negedge clk_i);
      if (bready_o && !rst_i) begin
        for (int i = 0; i < b_dly; i++) @(negedge clk_i);
        bvalid = 1'b1;
        bresp  = b_resp_cfg;
        while (bready_o) @(negedge clk_i);
        bvalid = 1'b0;
      end
    end
  end

  initial begin
    rvalid = 1'b0;
    rresp  = 2'b00;
    rdata  = '0;
    forever begin
      @(negedge clk_i);
      if (rready_o && !rst_i) begin
        for (int i = 0; i < r_dly; i++) @(negedge clk_i);
        rvalid = 1'b1;
        rdata  = r_data_cfg;
        rresp  = r_resp_cfg;
        while (rready_o) @(negedge clk_i);
        rvalid = 1'b0;
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  int compared = 0, mismatched = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, rdy_cnt = 0;
  int awv_cyc = 0, wv_cyc = 0, arv_cyc = 0;
  bit aw_pend = 0, w_pend = 0, ar_pend = 0, allow_drop = 0;
  logic [31:0] aw_pend_addr, w_pend_data, ar_pend_addr;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0] cap_wstrb = '0;
  logic [2:0] cap_awprot = '0, cap_arprot = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample just after the falling edge, check that no AXI valid
  // offered last cycle was withdrawn or changed before its handshake.
  task automatic step();
    @(negedge clk_i);
    #1;
    if (!rst_i && !allow_drop) begin
      if (aw_pend) chk("aw_hold", {awvalid_o, awaddr_o}, {1'b1, aw_pend_addr});
      if (w_pend)  chk("w_hold",  {wvalid_o, wdata_o},   {1'b1, w_pend_data});
      if (ar_pend) chk("ar_hold", {arvalid_o, araddr_o}, {1'b1, ar_pend_addr});
    end
    aw_pend = awvalid_o && !awready && !rst_i;
    w_pend  = wvalid_o && !wready && !rst_i;
    ar_pend = arvalid_o && !arready && !rst_i;
    aw_pend_addr = awaddr_o;
    w_pend_data  = wdata_o;
    ar_pend_addr = araddr_o;
    if (awvalid_o && awready) begin aw_hs++; cap_awaddr = awaddr_o; cap_awprot = awprot_o; end
    if (wvalid_o && wready)   begin w_hs++;  cap_wdata = wdata_o;   cap_wstrb = wstrb_o;   end
    if (arvalid_o && arready) begin ar_hs++; cap_araddr = araddr_o; cap_arprot = arprot_o; end
    if (bvalid && bready_o) b_hs++;
    if (awvalid_o) awv_cyc++;
    if (wvalid_o)  wv_cyc++;
    if (arvalid_o) arv_cyc++;
    if (mem_ready_o) rdy_cnt++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, mem_ready_o, mem_err_o}, 64'd0);
    chk({tag, "_addr"}, {awaddr_o, araddr_o}, 64'd0);
    chk({tag, "_data"}, {wdata_o, mem_rdata_o}, 64'd0);
    chk({tag, "_misc"}, {wstrb_o, awprot_o, arprot_o}, 64'd0);
  endtask

  // For reads, data is what the slave returns; lat counts request cycles including the ready cycle.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input logic instr,
                        input logic [1:0] resp, input bit perturb, output int lat);
    exp_t e, got;
    int aw0, w0, b0, ar0;
    bit done;
    if (wr) b_resp_cfg = resp;
    else begin
      r_resp_cfg = resp;
      r_data_cfg = data;
    end
    e.wr = wr; e.addr = addr; e.data = data; e.strb = strb;
    e.prot = {instr, 2'b00}; e.err = (resp != RESP_OKAY);
    sb_q.push_back(e);
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs;
    awv_cyc = 0; wv_cyc = 0; arv_cyc = 0;
    mem_valid = 1'b1; mem_addr = addr; mem_instr = instr;
    mem_wdata = wr ? data : 32'h5A5A_A5A5;
    mem_wstrb = wr ? strb : 4'h0;
    lat = 1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      lat++;
      if (perturb && i == 0) mem_wstrb = 4'hF;
      if (mem_ready_o) done = 1'b1;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    got = sb_q.pop_front();
    if (done) begin
      chk({tag, "_err"}, 64'(mem_err_o), 64'(got.err));
      if (got.wr) begin
        chk({tag, "_awaddr"}, cap_awaddr, got.addr);
        chk({tag, "_awprot"}, cap_awprot, got.prot);
        chk({tag, "_wdata"}, cap_wdata, got.data);
        chk({tag, "_wstrb"}, cap_wstrb, got.strb);
        chk({tag, "_hs"}, {32'(aw_hs - aw0), 16'(w_hs - w0), 8'(b_hs - b0), 8'(ar_hs - ar0)},
            {32'd1, 16'd1, 8'd1, 8'd0});
      end else begin
        chk({tag, "_araddr"}, cap_araddr, got.addr);
        chk({tag, "_arprot"}, cap_arprot, got.prot);
        chk({tag, "_rdata"}, mem_rdata_o, got.data);
        chk({tag, "_hs"}, {32'(ar_hs - ar0), 32'(aw_hs - aw0)}, {32'd1, 32'd0});
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    step();
    chk({tag, "_pulse"}, 64'(mem_ready_o), 64'd0);
  endtask

  int lat, r0;
  bit found;
  logic wr_r;
  logic [3:0] strb_r;

  initial begin
    rst_i = 1'b1;
    mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    repeat (3) step();
    check_zero("reset");
    rst_i = 1'b0;
    step();

    do_req("rd0", 1'b0, 32'h0300_0010, 32'hDEAD_BEEF, 4'h0, 1'b0, RESP_OKAY, 1'b0, lat);
    chk("rd0_lat", 64'(lat), 64'd4);
    chk("rd0_arv_cyc", 64'(arv_cyc), 64'd1);

    do_req("wr_zw", 1'b1, 32'h0300_0040, 32'h0102_0304, 4'hF, 1'b0, RESP_OKAY, 1'b0, lat);
    chk("wr_zw_lat", 64'(lat), 64'd4);

    // W accepted three cycles after AW
    w_dly = 3;
    do_req("wr0", 1'b1, 32'h0300_0020, 32'hCAFE_F00D, 4'b0011, 1'b0, RESP_OKAY, 1'b0, lat);
    chk("wr0_awv_cyc", 64'(awv_cyc), 64'd1);
    chk("wr0_wv_cyc", 64'(wv_cyc), 64'd4);
    chk("wr0_lat", 64'(lat), 64'd7);
    w_dly = 0;

    do_req("wr_slverr", 1'b1, 32'h0300_0080, 32'h1111_2222, 4'b1000, 1'b0, RESP_SLVERR, 1'b0, lat);
    do_req("rd_decerr", 1'b0, 32'h0400_0004, 32'h1234_5678, 4'h0, 1'b1, RESP_DECERR, 1'b0, lat);
    do_req("rd_exokay", 1'b0, 32'h0400_0008, 32'h8765_4321, 4'h0, 1'b0, RESP_EXOKAY, 1'b0, lat);
    do_req("rd_wstrb_chg", 1'b0, 32'h0300_0100, 32'hA5A5_0F0F, 4'h0, 1'b0, RESP_OKAY, 1'b1, lat);

    for (int k = 0; k < 12; k++) begin
      aw_dly = $urandom_range(0, 5); w_dly = $urandom_range(0, 5); ar_dly = $urandom_range(0, 5);
      b_dly = $urandom_range(0, 5);  r_dly = $urandom_range(0, 5);
      wr_r = 1'($urandom_range(0, 1));
      strb_r = wr_r ? 4'($urandom_range(1, 15)) : 4'h0;
      do_req("rnd", wr_r, $urandom & 32'hFFFF_FFFC, $urandom, strb_r, 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'b0, lat);
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;

    // reset while waiting for read data
    r_dly = 8;
    mem_valid = 1'b1; mem_addr = 32'h0300_0200; mem_wstrb = 4'h0; mem_instr = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (rready_o) found = 1'b1;
    end
    chk("rst_rd_r_reached", 64'(found), 64'd1);
    mem_valid = 1'b0;
    rst_i = 1'b1;
    step();
    check_zero("rst_mid");
    rst_i = 1'b0;
    r0 = rdy_cnt;
    repeat (12) step();
    chk("rst_no_ready", 64'(rdy_cnt - r0), 64'd0);
    r_dly = 0;
    do_req("rd_after_rst", 1'b0, 32'h0300_0010, 32'h0BAD_F00D, 4'h0, 1'b0, RESP_OKAY, 1'b0, lat);
    chk("rd_after_rst_lat", 64'(lat), 64'd4);

`ifdef MEM2AXI4L_TIMEOUT_EN
    // AR never accepted: arvalid held TB_TMO cycles, then error response with all-ones data
    begin
      exp_t e, got;
      ar_stuck = 1'b1;
      allow_drop = 1'b1;
      e.wr = 1'b0; e.addr = 32'h0500_0000; e.data = 32'hFFFF_FFFF; e.strb = 4'h0;
      e.prot = 3'b000; e.err = 1'b1;
      sb_q.push_back(e);
      arv_cyc = 0;
      mem_valid = 1'b1; mem_addr = e.addr; mem_wstrb = 4'h0; mem_instr = 1'b0;
      lat = 1;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
        step();
        lat++;
        if (mem_ready_o) found = 1'b1;
      end
      got = sb_q.pop_front();
      chk("tmo_done", 64'(found), 64'd1);
      chk("tmo_lat", 64'(lat), 64'(TB_TMO + 2));
      chk("tmo_arv_cyc", 64'(arv_cyc), 64'(TB_TMO));
      chk("tmo_rdata", mem_rdata_o, got.data);
      chk("tmo_err", 64'(mem_err_o), 64'(got.err));
      mem_valid = 1'b0;
      step();
      chk("tmo_idle", {arvalid_o, mem_ready_o}, 64'd0);
      ar_stuck = 1'b0;
      allow_drop = 1'b0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
